// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, colour constants and RGB helpers for the LED gradient fader
package led_pkg;

  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_e;

  // Which side of the midpoint the request falls on.
  typedef enum logic [1:0] {K_EQ, K_LT, K_GT} kind_e;

  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;

  function automatic int maxc(input int cw);
    return (1 << cw) - 1;
  endfunction

  function automatic logic [47:0] pack_rgb(input logic [15:0] r, input logic [15:0] g,
                                           input logic [15:0] b, input int cw);
    return (48'(r) << (2 * cw)) | (48'(g) << cw) | 48'(b);
  endfunction

  function automatic logic [15:0] unpack_chan(input logic [47:0] c, input int idx, input int cw);
    return 16'((c >> (idx * cw)) & 48'(maxc(cw)));
  endfunction

endpackage

// File: rtl/led_seq_divider.sv
// rtl/led_seq_divider.sv - restoring divider computing floor(num*MAXC/den) in N+CW fixed iterations
module led_seq_divider
  import led_pkg::*;
#(
  parameter int N  = 10,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [N-1:0]  num,
  input  logic [N-1:0]  den,
  output logic          done,
  output logic [CW-1:0] q
);
  localparam int NUMW = N + CW;
  localparam int CNTW = $clog2(NUMW + 1);
  localparam logic [CW-1:0] MAXC = CW'(maxc(CW));

  logic [NUMW-1:0] dq_q, dq_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    den_q, den_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N:0]      rem_sh;
  logic [N-1:0]    rem_sub;

  // dq holds the unconsumed dividend bits on top and the growing quotient below.
  always_comb begin
    dq_d    = dq_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    rem_sh  = {rem_q, dq_q[NUMW-1]};
    rem_sub = rem_sh[N-1:0] - den_q;
    if (start) begin
      dq_d  = NUMW'(num) * NUMW'(MAXC);
      rem_d = '0;
      den_d = den;
      cnt_d = CNTW'(NUMW);
    end else if (cnt_q != '0) begin
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d = rem_sub;
        dq_d  = {dq_q[NUMW-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[N-1:0];
        dq_d  = {dq_q[NUMW-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dq_q  <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNTW'(1));
  assign q    = dq_q[CW-1:0];

endmodule

// File: rtl/led_gradient_fader.sv
// rtl/led_gradient_fader.sv - index to red/yellow/green gradient with exact divider and fade
// Define LED_FADE_EN for a slew-limited fade of cor_led toward the target colour.
module led_gradient_fader
  import led_pkg::*;
#(
  parameter int N         = 10,
  parameter int CW        = 8,
  parameter int FADE_STEP = 4,
  parameter int FADE_DIV  = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    contador,
  input  logic [N-1:0]    mid_idx,
  input  logic [N-1:0]    max_idx,
  output logic            cor_valid,
  output logic            busy,
  output logic            fading,
  output logic [3*CW-1:0] cor_led
);
  localparam int RGBW = 3 * CW;
  localparam logic [CW-1:0] MAXC = CW'(maxc(CW));
  localparam logic [CW-1:0] ZERO = '0;

  if (FADE_STEP < 1 || FADE_DIV < 1) begin : g_param_check
    $error("led_gradient_fader: FADE_STEP and FADE_DIV must be at least 1");
  end

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d, kind_c;
  logic            sat_q, sat_d, sat_c;
  logic [N-1:0]    cnt_q, cnt_d, mid_q, mid_d, max_q, max_d;
  logic [N-1:0]    num_c, den_c, gt_den, delta;
  logic [RGBW-1:0] target_q, target_d, cor_led_q, cor_led_d, result;
  logic            cor_valid_q, cor_valid_d;
  logic [CW-1:0]   div_q, val;
  logic            div_done, accept;

  assign in_ready  = (state_q == IDLE) && reset_n;
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign cor_valid = cor_valid_q;
  assign cor_led   = cor_led_q;

  // Shortcut cases still run the divider (on 0/1) so latency never depends on the data.
  always_comb begin
    gt_den = (max_q > mid_q) ? max_q - mid_q : N'(1);
    delta  = cnt_q - mid_q;
    kind_c = K_EQ;
    sat_c  = 1'b0;
    num_c  = '0;
    den_c  = N'(1);
    if (cnt_q < mid_q) begin
      kind_c = K_LT;
      num_c  = cnt_q;
      den_c  = mid_q;
    end else if (cnt_q > mid_q) begin
      kind_c = K_GT;
      sat_c  = (delta >= gt_den);
      if (!sat_c) begin
        num_c = delta;
        den_c = gt_den;
      end
    end
  end

  led_seq_divider #(.N(N), .CW(CW)) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (state_q == LOAD),
    .num     (num_c),
    .den     (den_c),
    .done    (div_done),
    .q       (div_q)
  );

  always_comb begin
    val = sat_q ? MAXC : div_q;
    case (kind_q)
      K_EQ:    result = {MAXC, MAXC, ZERO};
      K_LT:    result = {MAXC, div_q, ZERO};
      default: result = {MAXC - val, MAXC, ZERO};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mid_d       = mid_q;
    max_d       = max_q;
    kind_d      = kind_q;
    sat_d       = sat_q;
    target_d    = target_q;
    cor_valid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = LOAD;
        cnt_d   = contador;
        mid_d   = mid_idx;
        max_d   = max_idx;
      end
      LOAD: begin
        state_d = DIV;
        kind_d  = kind_c;
        sat_d   = sat_c;
      end
      DIV: if (div_done) state_d = DONE;
      DONE: begin
        state_d     = IDLE;
        target_d    = result;
        cor_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_FADE_EN
  localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(FADE_DIV - 1);
  localparam logic [CW-1:0] STEP = CW'(FADE_STEP);

  logic [PW-1:0]   presc_q, presc_d;
  logic [RGBW-1:0] faded;
  logic [CW-1:0]   cur, tgt;
  logic            tick;

  // Each channel closes at most STEP of its gap per tick and lands exactly on the target.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    faded   = cor_led_q;
    cur     = '0;
    tgt     = '0;
    for (int i = 0; i < 3; i++) begin
      cur = cor_led_q[i*CW +: CW];
      tgt = target_q[i*CW +: CW];
      if (tgt > cur) faded[i*CW +: CW] = (tgt - cur > STEP) ? cur + STEP : tgt;
      else           faded[i*CW +: CW] = (cur - tgt > STEP) ? cur - STEP : tgt;
    end
    cor_led_d = tick ? faded : cor_led_q;
  end

  assign fading = (cor_led_q != target_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end
`else
  always_comb begin
    cor_led_d = (state_q == DONE) ? result : cor_led_q;
  end

  assign fading = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      kind_q      <= K_EQ;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      mid_q       <= '0;
      max_q       <= '0;
      target_q    <= '0;
      cor_led_q   <= '0;
      cor_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      mid_q       <= mid_d;
      max_q       <= max_d;
      target_q    <= target_d;
      cor_led_q   <= cor_led_d;
      cor_valid_q <= cor_valid_d;
    end
  end

endmodule
